// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, handshakes with imem, applies redirects/stalls.
// Optional fetch timeout (wait counter, ERROR state, fetch_error) enabled by `define FETCH_TIMEOUT_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  input  logic        stall,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        fetch_error
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD, ERROR} state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] next_pc;

  function automatic logic [31:0] add4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  assign pc_plus4  = add4(pc);
  assign imem_addr = pc;

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] wait_cnt;
  logic       timeout;

  // Counts consecutive not-ready cycles of the current fetch; any other outcome restarts it.
  assign timeout = (wait_cnt == 4'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
    end else if (state == REQ && !pc_src && !stall && !imem_ready) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= 4'd0;
    end
  end
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= next_state;
      pc    <= next_pc;
    end
  end

  always_comb begin
    next_state = state;
    next_pc    = pc;
    case (state)
      BOOT: next_state = REQ;
      REQ: begin
        if (pc_src) begin
          next_pc = branch_target;
        end else if (stall) begin
          next_state = HOLD;
        end else if (imem_ready) begin
          next_pc = pc_plus4;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (timeout) begin
          next_state = ERROR;
        end
`endif
      end
      HOLD: begin
        if (pc_src) begin
          next_pc    = branch_target;
          next_state = REQ;
        end else if (!stall) begin
          next_state = REQ;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      ERROR: next_state = ERROR;
`endif
      default: next_state = BOOT;
    endcase
  end

  // Write and flush are Mealy: they respond to the inputs in the same cycle.
  always_comb begin
    imem_req    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    fetch_error = 1'b0;
    case (state)
      REQ: begin
        imem_req = 1'b1;
        if (pc_src) begin
          if_id_flush = 1'b1;
        end else if (!stall && imem_ready) begin
          if_id_write = 1'b1;
        end
      end
      HOLD: if_id_flush = pc_src;
`ifdef FETCH_TIMEOUT_EN
      ERROR: fetch_error = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed test-plan sequence plus randomized traffic against a behavioural model.
module tb_fetch_sequencer;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int          MW  = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_src = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        if_id_write;
  logic        if_id_flush;
  logic        fetch_error;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.RESET_PC(RPC), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .branch_target(branch_target),
    .stall(stall), .imem_ready(imem_ready), .imem_req(imem_req),
    .imem_addr(imem_addr), .pc(pc), .pc_plus4(pc_plus4),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=booting, 1=fetching, 2=held by stall, 3=timed out.
  int          m_mode = 0;
  logic [31:0] m_pc   = RPC;
  int          m_miss = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_write", {31'd0, if_id_write}, 32'd0);
      check("rst_flush", {31'd0, if_id_flush}, 32'd0);
      check("rst_err", {31'd0, fetch_error}, 32'd0);
      check("rst_pc", pc, RPC);
      m_mode = 0;
      m_pc   = RPC;
      m_miss = 0;
    end else begin
      check("m_req", {31'd0, imem_req}, {31'd0, m_mode == 1});
      check("m_write", {31'd0, if_id_write},
            {31'd0, m_mode == 1 && !pc_src && !stall && imem_ready});
      check("m_flush", {31'd0, if_id_flush}, {31'd0, (m_mode == 1 || m_mode == 2) && pc_src});
      check("m_err", {31'd0, fetch_error}, {31'd0, m_mode == 3});
      check("m_pc", pc, m_pc);
      check("m_addr", imem_addr, m_pc);
      check("m_pc4", pc_plus4, m_pc + 32'd4);
      case (m_mode)
        0: m_mode = 1;
        1: begin
          if (pc_src) begin
            m_pc = branch_target; m_miss = 0;
          end else if (stall) begin
            m_mode = 2; m_miss = 0;
          end else if (imem_ready) begin
            m_pc = m_pc + 32'd4; m_miss = 0;
          end else begin
            m_miss++;
`ifdef FETCH_TIMEOUT_EN
            if (m_miss == MW) m_mode = 3;
`endif
          end
        end
        2: begin
          if (pc_src) begin
            m_pc = branch_target; m_mode = 1;
          end else if (!stall) begin
            m_mode = 1;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic cyc(input bit s, input logic [31:0] t, input bit st, input bit rdy);
    @(posedge clk); #1;
    pc_src = s; branch_target = t; stall = st; imem_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; imem_ready = 1'b1;
    @(negedge clk);
    check("boot_req", {31'd0, imem_req}, 32'd0);
    check("boot_write", {31'd0, if_id_write}, 32'd0);

    cyc(0, 0, 0, 1); check("f100_addr", imem_addr, 32'h100); check("f100_wr", {31'd0, if_id_write}, 32'd1);
    cyc(0, 0, 0, 1); check("f104_addr", imem_addr, 32'h104); check("f104_wr", {31'd0, if_id_write}, 32'd1);
    cyc(1, 32'h200, 0, 1);
    check("br_addr", imem_addr, 32'h108);
    check("br_flush", {31'd0, if_id_flush}, 32'd1);
    check("br_wr", {31'd0, if_id_write}, 32'd0);
    cyc(0, 0, 0, 1); check("tgt_addr", imem_addr, 32'h200); check("tgt_wr", {31'd0, if_id_write}, 32'd1);

    cyc(0, 0, 1, 1); check("st1_addr", imem_addr, 32'h204); check("st1_wr", {31'd0, if_id_write}, 32'd0);
    cyc(0, 0, 1, 1); check("hold_req", {31'd0, imem_req}, 32'd0); check("hold_pc", pc, 32'h204);
    cyc(0, 0, 0, 1); check("rel_req", {31'd0, imem_req}, 32'd0);
    cyc(0, 0, 0, 1); check("refetch_addr", imem_addr, 32'h204); check("refetch_wr", {31'd0, if_id_write}, 32'd1);

    cyc(1, 32'h300, 1, 1); check("both_flush", {31'd0, if_id_flush}, 32'd1); check("both_wr", {31'd0, if_id_write}, 32'd0);
    cyc(0, 0, 0, 1); check("both_req", {31'd0, imem_req}, 32'd1); check("both_addr", imem_addr, 32'h300);

    cyc(1, 32'hFFFF_FFF8, 0, 1);
    cyc(0, 0, 0, 1); check("wrap_a", imem_addr, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 1); check("wrap_b", imem_addr, 32'hFFFF_FFFC); check("wrap_p4", pc_plus4, 32'h0);
    cyc(0, 0, 0, 1); check("wrap_c", imem_addr, 32'h0);

    cyc(0, 0, 0, 1);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
`ifdef FETCH_TIMEOUT_EN
    check("to_err", {31'd0, fetch_error}, 32'd1);
    check("to_req", {31'd0, imem_req}, 32'd0);
    cyc(1, 32'h40, 0, 1);
    check("to_sticky", {31'd0, fetch_error}, 32'd1);
    check("to_wr", {31'd0, if_id_write}, 32'd0);
    cyc(0, 0, 0, 1); check("to_pc", pc, 32'h8);
`else
    check("nto_req", {31'd0, imem_req}, 32'd1);
    check("nto_err", {31'd0, fetch_error}, 32'd0);
    cyc(0, 0, 0, 1); check("nto_wr", {31'd0, if_id_write}, 32'd1); check("nto_addr", imem_addr, 32'h8);
    cyc(0, 0, 0, 1); check("nto_next", imem_addr, 32'hC);
`endif

    @(posedge clk); #1;
    rst_n = 1'b0; imem_ready = 1'b1; pc_src = 1'b0; stall = 1'b0;
    #1;
    check("arst_req", {31'd0, imem_req}, 32'd0);
    check("arst_wr", {31'd0, if_id_write}, 32'd0);
    check("arst_pc", pc, RPC);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("arst_boot", {31'd0, imem_req}, 32'd0);

    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      rst_n         = ($urandom_range(0, 199) != 0);
      pc_src        = ($urandom_range(0, 9) == 0);
      branch_target = $urandom;
      stall         = ($urandom_range(0, 4) == 0);
      imem_ready    = ($urandom_range(0, 9) < 7);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller for the pipeline's instruction-fetch stage. It owns the program counter and sequences every fetch against an instruction memory with a ready handshake. It applies branch redirects from the memory stage and load-use stalls from decode, and generates the IF/ID register write and flush controls. It sits between the hazard and branch logic and the fetch datapath (PC register, PC+4 adder, PC mux, instruction memory).

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 15, maximum consecutive not-ready cycles per fetch before fault (4-bit counter, legal 1..15).

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pc_src  in  1  branch/jump resolved taken; redirect to branch_target.
- branch_target  in  32  redirect address, sampled when pc_src=1.
- stall  in  1  load-use hazard from decode; hold PC and IF/ID.
- imem_ready  in  1  instruction memory has valid data for imem_addr this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; always equal to pc.
- pc  out  32  current PC (registered).
- pc_plus4  out  32  pc + 4, modulo 2^32.
- if_id_write  out  1  load IF/ID register this cycle.
- if_id_flush  out  1  clear IF/ID register to bubble this cycle.
- fetch_error  out  1  sticky fetch-timeout fault.

## Operation
- State register: BOOT, REQ, HOLD, ERROR. Reset state is BOOT.
- Reset values: pc=RESET_PC, wait_cnt=0, imem_req=0, if_id_write=0, if_id_flush=0, fetch_error=0.
- Input priority in every state except ERROR: pc_src > stall > normal flow.
- BOOT:
  - All outputs inactive.
  - Unconditionally moves to REQ on the next edge.
- REQ (imem_req=1):
  - pc_src=1, regardless of imem_ready: pc<=branch_target, if_id_flush=1, if_id_write=0, wait_cnt<=0, stay REQ. Any pending fetch is abandoned.
  - else stall=1: pc held, if_id_write=0, wait_cnt<=0, go HOLD. Data returned in this cycle is discarded and refetched later.
  - else imem_ready=1: if_id_write=1, pc<=pc_plus4, wait_cnt<=0, stay REQ.
  - else (not ready): wait_cnt<=wait_cnt+1. If wait_cnt==MAX_WAIT-1, go ERROR.
- HOLD (imem_req=0, if_id_write=0):
  - pc_src=1: pc<=branch_target, if_id_flush=1, go REQ.
  - else stall=0: go REQ.
  - else stay HOLD.
- ERROR:
  - imem_req=0, if_id_write=0, if_id_flush=0, fetch_error=1.
  - All inputs ignored; left only by rst_n.
- Arithmetic:
  - pc_plus4 is a 32-bit add that wraps (32'hFFFF_FFFC -> 32'h0000_0000).
  - branch_target is loaded as given; no alignment check.

## Timing
- if_id_write and if_id_flush are Mealy outputs: combinational from state and inputs, valid in the same cycle as the qualifying imem_ready, pc_src or stall.
- if_id_write and if_id_flush are never both 1.
- pc, state and wait_cnt update on the rising clk edge.
- Throughput: one instruction per cycle while imem_ready=1 and there is no hazard.
- Redirect latency: branch_target appears on imem_addr the cycle after pc_src=1.
- Stall recovery: the fetch is re-issued the cycle after stall deasserts.
- rst_n assertion mid-fetch clears everything immediately: no request and no IF/ID write in that cycle. BOOT follows deassertion.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - wait_cnt, the ERROR state and fetch_error are built as described.
- FETCH_TIMEOUT_EN undefined:
  - No counter and no ERROR state; REQ waits indefinitely for imem_ready.
  - fetch_error is tied to 0.
  - MAX_WAIT is unused.

## Test plan
- Reset with RESET_PC=32'h100, then imem_ready=1 constantly: BOOT for 1 cycle, then imem_addr steps 100,104,108 with if_id_write=1 each cycle.
- At pc=32'h108, pc_src=1 with branch_target=32'h200: if_id_flush=1 and if_id_write=0 that cycle; next imem_addr=32'h200.
- stall=1 for 2 cycles at pc=32'h204: if_id_write=0 and imem_req=0 in HOLD; pc stays 204; the fetch of 204 is reissued the cycle after stall drops.
- pc_src=1 and stall=1 together in REQ: redirect wins; flush=1; state stays REQ (no HOLD).
- imem_ready=0 for 15 cycles with FETCH_TIMEOUT_EN: fetch_error=1 and imem_req=0 persist until rst_n. Without the macro, the same stimulus keeps imem_req=1 and a late ready resumes fetch normally.
- pc=32'hFFFF_FFFC with ready: next pc=32'h0000_0000; pc_plus4 wraps correctly.
